// File: rtl/alu_seq_exec_pkg.sv
// Shared types and constants for the multi-cycle ALU execute stage.
// Opcodes, FSM states and flag bit positions live here.
package alu_seq_exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    // Shifts by zero finish in one cycle like the logic ops.
    function automatic logic is_iter(op_e op, logic shamt_nz);
        return (op == OP_MUL) ||
               (((op == OP_SHL) || (op == OP_SHR)) && shamt_nz);
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Start/busy/done bundle between the control unit and the ALU stage.
// The control unit is the master, the ALU the slave.
interface alu_seq_exec_if
    import alu_seq_exec_pkg::*;
#(
    parameter int DW = 8
);
    logic          start;
    op_e           op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic [1:0]    flag;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, flag
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, flag
    );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative datapath: 1-bit-per-cycle shifts and shift-add multiply.
// res_o/c_o show the value the accumulator takes on the current step.
module alu_iter_unit
    import alu_seq_exec_pkg::*;
#(
    parameter int DW = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          step_i,
    input  op_e           op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          last_o,
    output logic [DW-1:0] res_o,
    output logic          c_o
);
    localparam logic [SW:0] CNT_MUL = (SW+1)'(DW);
    localparam logic [SW:0] CNT_ONE = (SW+1)'(1);

    op_e             op_q;
    logic [2*DW-1:0] acc_q;
    logic [2*DW-1:0] acc_d;
    logic [DW-1:0]   mcand_q;
    logic [SW:0]     cnt_q;
    logic [DW-1:0]   lo;
    logic [DW-1:0]   hi;
    logic [DW:0]     sum;

    assign lo = acc_q[DW-1:0];
    assign hi = acc_q[2*DW-1:DW];

    // MUL keeps {partial, multiplier} in acc and retires one multiplier bit per step.
    always_comb begin
        acc_d = acc_q;
        c_o   = 1'b0;
        sum   = '0;
        unique case (1'b1)
            (op_q == OP_MUL): begin
                sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand_q} : '0);
                acc_d = {sum, lo[DW-1:1]};
                c_o   = |acc_d[2*DW-1:DW];
            end
            (op_q == OP_SHL): begin
                acc_d = {hi, lo[DW-2:0], 1'b0};
                c_o   = lo[DW-1];
            end
            default: begin
                acc_d = {hi, 1'b0, lo[DW-1:1]};
                c_o   = lo[0];
            end
        endcase
    end

    assign res_o  = acc_d[DW-1:0];
    assign last_o = (cnt_q == CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_ADD;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            op_q    <= op_i;
            mcand_q <= a_i;
            if (op_i == OP_MUL) begin
                acc_q <= {{DW{1'b0}}, b_i};
                cnt_q <= CNT_MUL;
            end else begin
                acc_q <= {{DW{1'b0}}, a_i};
                cnt_q <= {1'b0, b_i[SW-1:0]};
            end
        end else if (step_i && (cnt_q != '0)) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU execute stage: FSM, single-cycle ops and output regs.
// Shifts and multiply are delegated to alu_iter_unit.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
#(
    parameter int DW = 8,
    parameter int SW = 3
) (
    input logic           clk,
    input logic           rst,
    alu_seq_exec_if.slave bus
);
    state_e        state_q;
    state_e        state_d;
    logic [DW-1:0] result_q;
    logic [DW-1:0] result_d;
    logic [1:0]    flag_q;
    logic [1:0]    flag_d;

    logic          load;
    logic          step;
    logic          last;
    logic [DW-1:0] it_res;
    logic          it_c;

    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic [DW-1:0] r1;
    logic          c1;

    alu_iter_unit #(.DW(DW), .SW(SW)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .op_i   (bus.op),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .last_o (last),
        .res_o  (it_res),
        .c_o    (it_c)
    );

    // Ops that complete on the accept edge; zero-length shifts pass a through.
    always_comb begin
        sum  = {1'b0, bus.a} + {1'b0, bus.b} + {{DW{1'b0}}, bus.cin};
        diff = {1'b0, bus.a} - {1'b0, bus.b} - {{DW{1'b0}}, bus.cin};
        r1   = bus.a;
        c1   = 1'b0;
        unique case (bus.op)
            OP_ADD: begin
                r1 = sum[DW-1:0];
                c1 = sum[DW];
            end
            OP_SUB: begin
                r1 = diff[DW-1:0];
                c1 = diff[DW];
            end
            OP_AND: r1 = bus.a & bus.b;
            OP_OR:  r1 = bus.a | bus.b;
            OP_XOR: r1 = bus.a ^ bus.b;
            OP_SHL, OP_SHR, OP_MUL: r1 = bus.a;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flag_d   = flag_q;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_iter(bus.op, |bus.b[SW-1:0])) begin
                        load    = 1'b1;
                        state_d = S_EXEC;
                    end else begin
                        result_d       = r1;
                        flag_d[FLAG_C] = c1;
                        flag_d[FLAG_Z] = (r1 == '0);
                        state_d        = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                step = 1'b1;
                if (last) begin
                    result_d       = it_res;
                    flag_d[FLAG_C] = it_c;
                    flag_d[FLAG_Z] = (it_res == '0);
                    state_d        = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flag_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.flag   = flag_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: directed ops with hand-computed results.
// A negedge monitor pops expectations when done pulses.
module tb_alu_seq_exec;
    import alu_seq_exec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_exec_if #(.DW(8)) bus ();

    alu_seq_exec #(.DW(8), .SW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] r;
        logic [1:0] f;
        int         cyc;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    int         cyc      = 0;
    int         n_cmp    = 0;
    int         n_bad    = 0;
    logic [7:0] last_res = 8'h00;

    // cyc counts rising edges; the period after edge k is cycle k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.nm, "_result"}, int'(bus.result), int'(e.r));
                    chk({e.nm, "_flag"}, int'(bus.flag), int'(e.f));
                    chk({e.nm, "_done_cycle"}, cyc + 1, e.cyc);
                    last_res = bus.result;
                end
            end else if (bus.busy) begin
                chk("result_hold_exec", int'(bus.result), int'(last_res));
            end
        end
    end

    // Accept edge T is the next rising edge; done is expected in cycle T+lat.
    task automatic issue(input op_e op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin,
                         input logic [7:0] er, input logic [1:0] ef,
                         input int lat, input string nm);
        int w;
        w = 0;
        while (bus.busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (bus.busy) chk({nm, "_idle_timeout"}, 1, 0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        sb.push_back('{r: er, f: ef, cyc: cyc + 1 + lat, nm: nm});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.cin   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_flag", int'(bus.flag), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 2'b11, 1, "add_ff_01");
        chk("add_busy_t1", int'(bus.busy), 1);
        @(negedge clk);
        chk("add_busy_t2", int'(bus.busy), 0);

        issue(OP_ADD, 8'h7F, 8'h00, 1'b1, 8'h80, 2'b00, 1, "add_cin");
        issue(OP_SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 2'b10, 1, "sub_borrow");
        issue(OP_SUB, 8'h07, 8'h07, 1'b0, 8'h00, 2'b01, 1, "sub_zero");
        issue(OP_SUB, 8'h00, 8'h00, 1'b1, 8'hFF, 2'b10, 1, "sub_cin");
        issue(OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 2'b00, 1, "and");
        issue(OP_OR,  8'h00, 8'h00, 1'b0, 8'h00, 2'b01, 1, "or_zero");
        issue(OP_XOR, 8'hA5, 8'h0F, 1'b0, 8'hAA, 2'b00, 1, "xor");
        issue(OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 2'b01, 1, "xor_zero");

        issue(OP_SHL, 8'h81, 8'h03, 1'b0, 8'h08, 2'b00, 4, "shl_3");
        issue(OP_SHR, 8'h81, 8'h01, 1'b0, 8'h40, 2'b10, 2, "shr_1");
        issue(OP_SHL, 8'h81, 8'h08, 1'b0, 8'h81, 2'b00, 1, "shl_0");
        issue(OP_SHR, 8'h01, 8'h07, 1'b0, 8'h00, 2'b01, 8, "shr_7");

        issue(OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 2'b11, 9, "mul_10_10");
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, 8'h01, 2'b10, 9, "mul_ff_ff");

        // start held high through a multiply; only the post-done one counts
        issue(OP_MUL, 8'h0C, 8'h0B, 1'b0, 8'h84, 2'b00, 9, "mul_0c_0b");
        begin
            int  w;
            bit  seen;
            w    = 0;
            seen = 1'b0;
            while (!seen && w < 30) begin
                bus.start = 1'b1;
                bus.op    = OP_ADD;
                bus.a     = 8'h01;
                bus.b     = 8'h01;
                bus.cin   = 1'b0;
                @(negedge clk);
                seen = bus.done;
                w++;
            end
            chk("spam_done_seen", int'(seen), 1);
            @(negedge clk);
            chk("spam_idle_after_done", int'(bus.busy), 0);
            sb.push_back('{r: 8'h02, f: 2'b00, cyc: cyc + 2,
                           nm: "b2b_add"});
            @(negedge clk);
            bus.start = 1'b0;
            chk("b2b_busy", int'(bus.busy), 1);
        end

        // reset in the middle of a multiply aborts it silently
        issue(OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 2'b11, 9, "mul_abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_result", int'(bus.result), 0);
        chk("abort_flag", int'(bus.flag), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(bus.done), 0);
        end

        issue(OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 2'b00, 1, "add_after_rst");
        issue(OP_SHL, 8'h03, 8'h02, 1'b0, 8'h0C, 2'b00, 3, "shl_2");

        begin
            int w;
            w = 0;
            while (sb.size() != 0 && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk("scoreboard_drained", sb.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
